// File: rtl/conv_output_writer_if.sv
// Handshake/bus bundle between the convolution fill counter side and the output writer.
// The writer uses the slave modport; the producer/bench drives through master.
interface conv_output_writer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 14
);
    // Strobes: a result beat exists in every cycle En is high; the writer never
    // stalls its source, so there is no ready signal.
    logic                  Start;
    logic                  En;
    logic                  Valid_In;
    logic [DATA_WIDTH-1:0] Data_In;
    logic                  Wr_En;
    logic [ADDR_WIDTH-1:0] Wr_Addr;
    logic [DATA_WIDTH-1:0] Wr_Data;
    logic                  Busy;
    logic                  Done;
    logic [1:0]            State_Dbg;

    modport master (
        output Start, En, Valid_In, Data_In,
        input  Wr_En, Wr_Addr, Wr_Data, Busy, Done, State_Dbg
    );

    modport slave (
        input  Start, En, Valid_In, Data_In,
        output Wr_En, Wr_Addr, Wr_Data, Busy, Done, State_Dbg
    );
endinterface

// File: rtl/conv_output_writer.sv
// Drops line-buffer wrap-around columns and writes legal conv pixels to the output RAM.
// Optional macro CONV_OUT_RELU_EN clamps negative written data to zero.
module conv_output_writer #(
    parameter int DATA_WIDTH  = 16,
    parameter int IMG_WIDTH   = 100,
    parameter int IMG_HEIGHT  = 100,
    parameter int KERNEL_SIZE = 3,
    parameter int ADDR_WIDTH  = 14
) (
    input logic Clk,
    input logic Rst,
    conv_output_writer_if.slave bus
);
    localparam int OUT_W = IMG_WIDTH - KERNEL_SIZE + 1;
    localparam int OUT_H = IMG_HEIGHT - KERNEL_SIZE + 1;
    localparam int COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int ROW_W = (OUT_H > 1) ? $clog2(OUT_H) : 1;

    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(OUT_H - 1);
    localparam logic [COL_W-1:0] KEEP_FROM = COL_W'(KERNEL_SIZE - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FILL   = 2'd1,
        S_STREAM = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [COL_W-1:0]      col_q, col_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [DATA_WIDTH-1:0] kept_data;

    logic accept;
    logic clear;
    logic keep;
    logic busy;
    logic done;
    logic last_beat;

    // The beat sitting at the far corner of the output map ends the frame.
    assign last_beat = (col_q == COL_LAST) && (row_q == ROW_LAST);

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (bus.Start) state_d = S_FILL;
            S_FILL:   if (bus.En && bus.Valid_In) state_d = last_beat ? S_DONE : S_STREAM;
            S_STREAM: if (bus.En && last_beat) state_d = S_DONE;
            S_DONE:   if (bus.Start) state_d = S_FILL;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        accept = 1'b0;
        clear  = 1'b0;
        busy   = 1'b0;
        done   = 1'b0;
        case (state_q)
            S_IDLE:   clear  = bus.Start;
            S_FILL:   begin accept = bus.En && bus.Valid_In; busy = 1'b1; end
            S_STREAM: begin accept = bus.En; busy = 1'b1; end
            S_DONE:   begin clear = bus.Start; done = 1'b1; end
            default:  ;
        endcase
        keep = accept && (col_q >= KEEP_FROM);
    end

`ifdef CONV_OUT_RELU_EN
    assign kept_data = bus.Data_In[DATA_WIDTH-1] ? '0 : bus.Data_In;
`else
    assign kept_data = bus.Data_In;
`endif

    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        addr_d = addr_q;
        if (clear) begin
            col_d  = '0;
            row_d  = '0;
            addr_d = '0;
        end else if (accept) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
            if (keep) addr_d = addr_q + ADDR_WIDTH'(1);
        end
    end

    // Write register: address/data hold between writes, strobe is one cycle per kept beat.
    always_comb begin
        wr_en_d   = keep;
        wr_addr_d = keep ? addr_q : wr_addr_q;
        wr_data_d = keep ? kept_data : wr_data_q;
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            col_q     <= '0;
            row_q     <= '0;
            addr_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            col_q     <= col_d;
            row_q     <= row_d;
            addr_q    <= addr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign bus.Wr_En     = wr_en_q;
    assign bus.Wr_Addr   = wr_addr_q;
    assign bus.Wr_Data   = wr_data_q;
    assign bus.Busy      = busy;
    assign bus.Done      = done;
    assign bus.State_Dbg = state_q;

    // OUT_W only documents the map geometry; the keep rule already encodes it.
    localparam int OUT_PIXELS = OUT_W * OUT_H;
    initial_addr_fits : assert property (@(posedge Clk) (2 ** ADDR_WIDTH) >= OUT_PIXELS);
endmodule

// File: tb/tb_conv_output_writer.sv
// Self-checking bench for conv_output_writer on an 8x8 image with a 3x3 kernel.
module tb_conv_output_writer;
    localparam int DW    = 16;
    localparam int AW    = 14;
    localparam int IW    = 8;
    localparam int IH    = 8;
    localparam int K     = 3;
    localparam int OW    = IW - K + 1;
    localparam int OH    = IH - K + 1;
    localparam int NPIX  = OW * OH;
    localparam int BEATS = OH * IW;
    localparam int NVEC  = 6;

    typedef struct {
        logic [DW-1:0] din;
        logic [DW-1:0] exp;
    } vec_t;

    logic clk;
    logic rst_n;

    conv_output_writer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    conv_output_writer #(
        .DATA_WIDTH(DW), .IMG_WIDTH(IW), .IMG_HEIGHT(IH),
        .KERNEL_SIZE(K), .ADDR_WIDTH(AW)
    ) dut (
        .Clk(clk),
        .Rst(rst_n),
        .bus(bus)
    );

    int            n_tests = 0;
    int            n_fail  = 0;
    int            wr_seen = 0;
    bit            gap_mode = 1'b0;
    logic          prev_wr = 1'b0;
    logic [AW+DW-1:0] exp_q[$];
    vec_t          tbl[NVEC];

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [DW-1:0] model_data(input logic [DW-1:0] d);
`ifdef CONV_OUT_RELU_EN
        model_data = d[DW-1] ? '0 : d;
`else
        model_data = d;
`endif
    endfunction

    // Scoreboard: every observed write must match the head of the expected queue
    always @(negedge clk) begin
        logic [AW+DW-1:0] e;
        logic [AW-1:0]    ea;
        if (rst_n && bus.Wr_En === 1'b1) begin
            wr_seen++;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write",
                         bus.Wr_Addr, bus.Wr_Data);
            end else begin
                e  = exp_q.pop_front();
                ea = e[AW+DW-1:DW];
                check("wr_addr", 32'(bus.Wr_Addr), 32'(ea));
                check("wr_data", 32'(bus.Wr_Data), 32'(e[DW-1:0]));
                check("done_on_write", 32'(bus.Done), 32'(ea == AW'(NPIX - 1)));
                check("busy_on_write", 32'(bus.Busy), 32'(ea != AW'(NPIX - 1)));
                if (gap_mode) check("no_back_to_back", 32'(prev_wr), 32'(0));
            end
        end
        prev_wr = rst_n && (bus.Wr_En === 1'b1);
    end

    // Driver: one frame; mode 0 = beat index, 1 = random, 2 = vector table on kept beats
    task automatic run_frame(input int valid_delay, input bit gapped, input int mode,
                             input int glitch_beat, input int abort_writes,
                             output bit aborted);
        int            kept;
        logic [DW-1:0] d;
        logic [DW-1:0] ed;
        kept    = 0;
        aborted = 1'b0;
        wr_seen = 0;
        gap_mode = gapped;
        bus.Start    = 1'b1;
        bus.En       = 1'b1;
        bus.Valid_In = 1'b0;
        bus.Data_In  = DW'($urandom);
        tick();
        bus.Start = 1'b0;
        check("busy_after_start", 32'(bus.Busy), 32'(1));
        check("done_after_start", 32'(bus.Done), 32'(0));
        repeat (valid_delay) begin
            bus.Data_In = DW'($urandom_range(0, 65535));
            tick();
        end
        bus.Valid_In = 1'b1;
        for (int b = 0; b < BEATS; b++) begin
            d = (mode == 0) ? DW'(b) : DW'($urandom);
            ed = model_data(d);
            if ((b % IW) >= K - 1) begin
                if (mode == 2) begin
                    d  = tbl[kept % NVEC].din;
                    ed = tbl[kept % NVEC].exp;
                end
                exp_q.push_back({AW'(kept), ed});
                kept++;
            end
            bus.Data_In = d;
            bus.En      = 1'b1;
            bus.Start   = (b == glitch_beat);
            tick();
            bus.Start = 1'b0;
            if (abort_writes > 0 && wr_seen >= abort_writes) begin
                aborted = 1'b1;
                break;
            end
            if (gapped) begin
                bus.En      = 1'b0;
                bus.Data_In = DW'($urandom);
                tick();
            end
        end
        if (!aborted) begin
            bus.En = 1'b0;
            tick();
            tick();
            check("frame_queue_drained", 32'(exp_q.size()), 32'(0));
            check("frame_write_count", 32'(wr_seen), 32'(NPIX));
            check("done_at_end", 32'(bus.Done), 32'(1));
            check("busy_at_end", 32'(bus.Busy), 32'(0));
            check("state_at_end", 32'(bus.State_Dbg), 32'(3));
        end
        gap_mode = 1'b0;
    endtask

    initial begin
        bit ab;
        // Vector table: kept-beat data and the value the RAM must receive
        tbl[0].din = 16'hFFFB; tbl[1].din = 16'h0007; tbl[2].din = 16'h8000;
        tbl[3].din = 16'h7FFF; tbl[4].din = 16'h0000; tbl[5].din = 16'hFFFF;
`ifdef CONV_OUT_RELU_EN
        tbl[0].exp = 16'h0000; tbl[1].exp = 16'h0007; tbl[2].exp = 16'h0000;
        tbl[3].exp = 16'h7FFF; tbl[4].exp = 16'h0000; tbl[5].exp = 16'h0000;
`else
        tbl[0].exp = 16'hFFFB; tbl[1].exp = 16'h0007; tbl[2].exp = 16'h8000;
        tbl[3].exp = 16'h7FFF; tbl[4].exp = 16'h0000; tbl[5].exp = 16'hFFFF;
`endif

        // Reset then idle with no Start
        rst_n        = 1'b0;
        bus.Start    = 1'b0;
        bus.En       = 1'b1;
        bus.Valid_In = 1'b0;
        bus.Data_In  = '0;
        repeat (3) tick();
        check("reset_wr_en", 32'(bus.Wr_En), 32'(0));
        check("reset_wr_addr", 32'(bus.Wr_Addr), 32'(0));
        check("reset_wr_data", 32'(bus.Wr_Data), 32'(0));
        check("reset_busy", 32'(bus.Busy), 32'(0));
        check("reset_done", 32'(bus.Done), 32'(0));
        check("reset_state", 32'(bus.State_Dbg), 32'(0));
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.Data_In = DW'($urandom);
            tick();
            check("idle_outputs", 32'({bus.Wr_En, bus.Busy, bus.Done}), 32'(0));
        end

        // Full frame, En constant, Valid_In rises 5 cycles after Start
        run_frame(5, 1'b0, 0, -1, 0, ab);
        // DONE must hold without writes
        repeat (3) tick();
        check("done_holds", 32'(bus.Done), 32'(1));

        // Gapped En frame from DONE with random data
        run_frame(3, 1'b1, 1, -1, 0, ab);

        // Restart from DONE again; Start pulsed mid-STREAM must be ignored
        run_frame(2, 1'b0, 0, 10, 0, ab);

        // Reset mid-frame after the 20th write
        run_frame(1, 1'b0, 1, -1, 20, ab);
        check("abort_reached", 32'(ab), 32'(1));
        rst_n = 1'b0;
        #1;
        check("abort_wr_en", 32'(bus.Wr_En), 32'(0));
        check("abort_busy", 32'(bus.Busy), 32'(0));
        check("abort_done", 32'(bus.Done), 32'(0));
        check("abort_state", 32'(bus.State_Dbg), 32'(0));
        exp_q.delete();
        bus.En = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (5) tick();
        check("post_abort_idle", 32'({bus.Wr_En, bus.Busy, bus.Done}), 32'(0));

        // Table-driven data frame (sign handling) restarting at address 0
        run_frame(4, 1'b0, 2, -1, 0, ab);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
